// File: rtl/aes_ctr_pkg.sv
// Shared AES-CTR definitions: FSM state encoding and counter-block assembly.
package aes_ctr_pkg;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} ctr_state_t;

  // IV goes to the MSBs, the low ctr_w bits carry the counter.
  function automatic logic [AES_BLOCK_W-1:0] ctr_concat(input logic [AES_BLOCK_W-1:0] iv,
                                                        input logic [AES_BLOCK_W-1:0] ctr,
                                                        input int ctr_w);
    logic [AES_BLOCK_W-1:0] one;
    logic [AES_BLOCK_W-1:0] mask;
    one  = 1;
    mask = (one << ctr_w) - one;
    return (iv << ctr_w) | (ctr & mask);
  endfunction
endpackage

// File: rtl/ctr_block_gen_if.sv
// Config handshake plus counter-block output stream of ctr_block_gen.
interface ctr_block_gen_if #(
  parameter int BLOCK_W = 128,
  parameter int CTR_W   = 64,
  parameter int NB_W    = 32
);
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [BLOCK_W-CTR_W-1:0] cfg_iv;
  logic [CTR_W-1:0]         cfg_ctr;
  logic [NB_W-1:0]          cfg_num;
  logic                     abort;
  logic                     out_valid;
  logic                     out_ready;
  logic [BLOCK_W-1:0]       out_block;
  logic                     done;
  logic                     wrapped;
  logic                     err;

  modport master (
    output cfg_valid, cfg_iv, cfg_ctr, cfg_num, abort, out_ready,
    input  cfg_ready, out_valid, out_block, done, wrapped, err
  );

  modport slave (
    input  cfg_valid, cfg_iv, cfg_ctr, cfg_num, abort, out_ready,
    output cfg_ready, out_valid, out_block, done, wrapped, err
  );
endinterface

// File: rtl/ctr_incr.sv
// Combinational W-bit counter incrementer; carry flags the all-ones value.
module ctr_incr #(
  parameter int W = 64
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] sum,
  output logic         carry
);
  assign sum   = value + W'(1);
  assign carry = &value;
endmodule

// File: rtl/ctr_block_gen.sv
// AES-CTR counter-block generator: emits {iv, ctr} blocks, one per accepted transfer.
module ctr_block_gen
  import aes_ctr_pkg::*;
#(
  parameter int BLOCK_W = 128,
  parameter int CTR_W   = 64,
  parameter int NB_W    = 32,
  parameter bit WRAP_EN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  ctr_block_gen_if.slave bus
);
  localparam int IV_W = BLOCK_W - CTR_W;

  ctr_state_t       state;
  logic [IV_W-1:0]  iv_reg;
  logic [CTR_W-1:0] ctr_reg;
  logic [NB_W-1:0]  remaining;
  logic             cfg_ready_r, out_valid_r, done_r, wrapped_r, err_r;

  logic [CTR_W-1:0]       ctr_sum;
  logic                   ctr_max;
  logic                   hs;
  logic [AES_BLOCK_W-1:0] blk_full;

  ctr_incr #(.W(CTR_W)) u_incr (
    .value (ctr_reg),
    .sum   (ctr_sum),
    .carry (ctr_max)
  );

  assign hs       = out_valid_r & bus.out_ready;
  assign blk_full = ctr_concat(AES_BLOCK_W'(iv_reg), AES_BLOCK_W'(ctr_reg), CTR_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      iv_reg      <= '0;
      ctr_reg     <= '0;
      remaining   <= '0;
      cfg_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      wrapped_r   <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.cfg_valid) begin
          iv_reg      <= bus.cfg_iv;
          ctr_reg     <= bus.cfg_ctr;
          remaining   <= bus.cfg_num;
          wrapped_r   <= 1'b0;
          err_r       <= 1'b0;
          cfg_ready_r <= 1'b0;
          if (bus.cfg_num == '0) begin
            state  <= DONE;
            done_r <= 1'b1;
          end else begin
            state       <= RUN;
            out_valid_r <= 1'b1;
          end
        end
        RUN: if (bus.abort) begin
          // abort beats a coincident handshake: nothing more leaves
          state       <= IDLE;
          out_valid_r <= 1'b0;
          cfg_ready_r <= 1'b1;
        end else if (hs) begin
          remaining <= remaining - NB_W'(1);
          if (remaining == NB_W'(1)) begin
            ctr_reg     <= ctr_sum;
            state       <= DONE;
            out_valid_r <= 1'b0;
            done_r      <= 1'b1;
          end else if (ctr_max && !WRAP_EN) begin
            // hold the all-ones value; the wrapped block is never exposed
            state       <= ERR;
            out_valid_r <= 1'b0;
            err_r       <= 1'b1;
          end else begin
            ctr_reg <= ctr_sum;
            if (ctr_max) wrapped_r <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          cfg_ready_r <= 1'b1;
        end
        ERR: if (bus.abort) begin
          state       <= IDLE;
          err_r       <= 1'b0;
          cfg_ready_r <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_block = blk_full[BLOCK_W-1:0];
  assign bus.done      = done_r;
  assign bus.wrapped   = wrapped_r;
  assign bus.err       = err_r;
endmodule

// File: doc/ctr_block_gen.md
Name: ctr_block_gen

Overview:
- Parametrised AES-CTR counter-block generator. Produces a stream of BLOCK_W-bit counter blocks {nonce, counter} for the AES core, one per accepted transfer.
- Takes a nonce/IV, a start counter and a block count through a config handshake. Emits the blocks on a valid/ready stream and handles counter overflow according to a mode parameter.
- Sits between the key/IV setup logic and the AES cipher input. The XOR-with-ciphertext stage consumes the keystream downstream.

Parameters:
- BLOCK_W, 128, total counter-block width (AES block size).
- CTR_W, 64, counter field width in bits. IV field width is BLOCK_W-CTR_W. Legal range is 1..BLOCK_W-1.
- NB_W, 32, width of the block-count request.
- WRAP_EN, 1, overflow policy. 1: counter wraps to 0 and sets a sticky flag. 0: overflow is an error and generation halts.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  high only in IDLE.
- cfg_iv  in  BLOCK_W-CTR_W  nonce/IV, placed in the upper field.
- cfg_ctr  in  CTR_W  initial counter, placed in the lower field.
- cfg_num  in  NB_W  number of blocks to emit.
- abort  in  1  cancel the current job.
- out_valid  out  1  out_block is valid.
- out_ready  in  1  downstream accepts.
- out_block  out  BLOCK_W  {iv_reg, ctr_reg}, IV at the MSBs.
- done  out  1  one-cycle pulse when the job completes.
- wrapped  out  1  sticky: the counter wrapped during the current job.
- err  out  1  overflow error (WRAP_EN=0 only).

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state=IDLE; iv_reg, ctr_reg and remaining are cleared to 0.
  - Outputs: out_valid=0, cfg_ready=1 (IDLE), done=0, wrapped=0, err=0, out_block=0.
  - rst overrides all other inputs, including in the middle of a job.
- States: IDLE, RUN, DONE, ERR.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch iv, ctr and num, clear wrapped and err.
  - If num==0, go to DONE; otherwise go to RUN.
- RUN:
  - out_valid=1. The first block appears the cycle after config acceptance (latency 1).
  - Handshake = out_valid & out_ready. Without a handshake, out_block holds stable.
  - On each handshake: remaining decrements and ctr_reg increments modulo 2^CTR_W. Only the counter field changes; the IV field never changes.
  - If remaining==1 at the handshake, go to DONE.
- Overflow: a handshake with ctr_reg all-ones and remaining>1.
  - WRAP_EN=1: ctr_reg becomes 0, wrapped is set, and RUN continues.
  - WRAP_EN=0: go to ERR. The all-ones block was delivered; the wrapped block is never emitted.
  - Emitting all-ones as the final block (remaining==1) is not an overflow.
- DONE: done=1 for exactly one cycle, out_valid=0, then go to IDLE.
- ERR:
  - err=1, out_valid=0, cfg_ready=0.
  - Held until abort or rst. abort returns to IDLE with err cleared.
- abort:
  - In RUN or ERR: next state is IDLE, out_valid drops the next cycle, and done is not pulsed.
  - An abort arriving in the same cycle as a handshake wins: no further blocks are emitted.
  - In IDLE or DONE: ignored.
- Simultaneous events:
  - cfg_valid is ignored outside IDLE.
  - A new config can be accepted in the IDLE cycle right after DONE. Back-to-back jobs therefore have a 2-cycle gap.
- wrapped remains readable after DONE until the next config acceptance or rst.
- Arithmetic: counter and remaining are unsigned. No saturation is applied except as described above.

Decomposition:
- Shared package aes_ctr_pkg:
  - localparam AES_BLOCK_W=128.
  - typedef enum logic[1:0] ctr_state_t {IDLE, RUN, DONE, ERR}.
  - Helper function ctr_concat(iv, ctr).
- One sub-module is natural: ctr_incr. It is a combinational CTR_W-bit incrementer with a carry-out/all-ones flag, reused by the GCM counter logic.
- The FSM and registers stay in ctr_block_gen.

Test Plan:
- Basic job: cfg_iv=64'h0123456789ABCDEF, cfg_ctr=0, cfg_num=3, out_ready=1 -> out_block takes the values ...CDEF_0000000000000000, then ..._0001, then ..._0002 on consecutive cycles, first one cycle after acceptance; done pulses the cycle after the third handshake.
- Backpressure: same job with out_ready toggling 1,0,0,1,1 -> out_block is stable while stalled, exactly 3 distinct blocks are emitted in order, and there are no duplicates.
- Wrap (WRAP_EN=1): cfg_ctr=64'hFFFF_FFFF_FFFF_FFFE, cfg_num=4 -> counter sequence FFFE, FFFF, 0000, 0001; wrapped=1 from the cycle after the FFFF handshake; done pulses.
- Overflow error (WRAP_EN=0): cfg_ctr=all-ones, cfg_num=2 -> one all-ones block, then err=1, out_valid=0, no done pulse; abort -> IDLE with err=0. Also cfg_ctr=all-ones, cfg_num=1 -> DONE with err=0.
- Zero-length and abort: cfg_num=0 -> no out_valid, done pulses 1 cycle after acceptance. Second job with cfg_num=10 and abort after 4 handshakes -> no 5th block, no done, cfg_ready=1 the next cycle.
- Reset mid-job: rst asserted during RUN with CTR_W=32, BLOCK_W=128 -> next cycle all outputs are at reset values; a fresh config works normally.
